// File: rtl/vga_sync_if.sv
// Output bundle of the VGA timing generator: sync pulses, blanking flag,
// pixel strobe and the current raster position.
interface vga_sync_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;

    modport master (
        output hsync, vsync, video_on, p_tick, pixel_x, pixel_y
    );

    modport slave (
        input  hsync, vsync, video_on, p_tick, pixel_x, pixel_y
    );
endinterface

// File: rtl/vga_sync.sv
// VGA raster timing generator: divides clk into a pixel strobe, runs the
// horizontal/vertical position counters and decodes sync and blanking.
module vga_sync #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int TICK_DIV    = 2,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0]       H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VISIBLE    = 10'(H_DISPLAY);
    localparam logic [9:0]       V_VISIBLE    = 10'(V_DISPLAY);
    localparam logic [9:0]       H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]       H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]       V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]       V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_hsync;
    logic             r_vsync;
    logic             w_tick;
    logic [9:0]       w_xNext;
    logic [9:0]       w_yNext;
    logic             w_hActive;
    logic             w_vActive;

    assign w_tick = (r_div == DIV_LAST);

    always_comb begin
        w_xNext = r_x;
        w_yNext = r_y;
        if (w_tick) begin
            if (r_x == H_LAST) begin
                w_xNext = '0;
                w_yNext = (r_y == V_LAST) ? '0 : r_y + 10'd1;
            end else begin
                w_xNext = r_x + 10'd1;
            end
        end
    end

    // Sync windows decode the next position so the pulses line up with the
    // counters they describe instead of trailing them by one pixel.
    assign w_hActive = (w_xNext >= H_SYNC_FIRST) && (w_xNext <= H_SYNC_LAST);
    assign w_vActive = (w_yNext >= V_SYNC_FIRST) && (w_yNext <= V_SYNC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
        end else begin
            r_div   <= w_tick ? '0 : r_div + DIV_W'(1);
            r_x     <= w_xNext;
            r_y     <= w_yNext;
            r_hsync <= w_hActive ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync <= w_vActive ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    assign vga.p_tick   = w_tick;
    assign vga.pixel_x  = r_x;
    assign vga.pixel_y  = r_y;
    assign vga.hsync    = r_hsync;
    assign vga.vsync    = r_vsync;
    assign vga.video_on = (r_x < H_VISIBLE) && (r_y < V_VISIBLE);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a full-size 640x480 instance and a shrunken raster with
// TICK_DIV=4 and active-high sync, both compared every clk against a model.
module tb_vga_sync;

    localparam int B_HD  = 8;
    localparam int B_HF  = 2;
    localparam int B_HS  = 3;
    localparam int B_HB  = 2;
    localparam int B_VD  = 6;
    localparam int B_VF  = 2;
    localparam int B_VS  = 2;
    localparam int B_VB  = 3;
    localparam int B_DIV = 4;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   k     = 0;
    int   nChecks = 0;
    int   nFails  = 0;

    always #10 clk = ~clk;

    vga_sync_if ifA ();
    vga_sync_if ifB ();

    vga_sync dutA (
        .clk   (clk),
        .reset (reset),
        .vga   (ifA)
    );

    vga_sync #(
        .H_DISPLAY   (B_HD),
        .H_FRONT     (B_HF),
        .H_SYNC      (B_HS),
        .H_BACK      (B_HB),
        .V_DISPLAY   (B_VD),
        .V_FRONT     (B_VF),
        .V_SYNC      (B_VS),
        .V_BACK      (B_VB),
        .TICK_DIV    (B_DIV),
        .SYNC_ACTIVE (1'b1)
    ) dutB (
        .clk   (clk),
        .reset (reset),
        .vga   (ifB)
    );

    // The raster position is simply the number of whole pixel periods since
    // reset release, folded onto the frame.
    function automatic exp_t refModel(input int clks, input int hd, input int hf,
                                      input int hsw, input int hb, input int vd,
                                      input int vf, input int vsw, input int vb,
                                      input int dv, input logic act);
        exp_t e;
        int hTot, vTot, ticks, pos, x, y;
        hTot  = hd + hf + hsw + hb;
        vTot  = vd + vf + vsw + vb;
        ticks = clks / dv;
        pos   = ticks % (hTot * vTot);
        x     = pos % hTot;
        y     = pos / hTot;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.pt  = ((clks % dv) == dv - 1);
        e.hs  = (x >= hd + hf && x < hd + hf + hsw) ? act : ~act;
        e.vs  = (y >= vd + vf && y < vd + vf + vsw) ? act : ~act;
        e.von = (x < hd) && (y < vd);
        return e;
    endfunction

    task automatic checkField(input string tag, input int observed, input int expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d (clk %0d)", tag, observed, expected, k);
        end
    endtask

    task automatic checkOutput();
        exp_t ea, eb;
        ea = refModel(k, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0);
        eb = refModel(k, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, B_DIV, 1'b1);
        checkField("A.pixel_x",  int'(ifA.pixel_x),  int'(ea.x));
        checkField("A.pixel_y",  int'(ifA.pixel_y),  int'(ea.y));
        checkField("A.hsync",    int'(ifA.hsync),    int'(ea.hs));
        checkField("A.vsync",    int'(ifA.vsync),    int'(ea.vs));
        checkField("A.video_on", int'(ifA.video_on), int'(ea.von));
        checkField("A.p_tick",   int'(ifA.p_tick),   int'(ea.pt));
        checkField("B.pixel_x",  int'(ifB.pixel_x),  int'(eb.x));
        checkField("B.pixel_y",  int'(ifB.pixel_y),  int'(eb.y));
        checkField("B.hsync",    int'(ifB.hsync),    int'(eb.hs));
        checkField("B.vsync",    int'(ifB.vsync),    int'(eb.vs));
        checkField("B.video_on", int'(ifB.video_on), int'(eb.von));
        checkField("B.p_tick",   int'(ifB.p_tick),   int'(eb.pt));
    endtask

    task automatic applyStimulus(input logic r);
        reset = r;
        @(posedge clk);
        #1;
        k = r ? 0 : k + 1;
        checkOutput();
    endtask

    initial begin
        int firstV, secondV, hCount, hLowA;
        logic prevVs, prevHs;

        $display("[TB] reset hold");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1);
        checkField("reset A.hsync idle high", int'(ifA.hsync), 1);
        checkField("reset A.video_on", int'(ifA.video_on), 1);

        $display("[TB] tick cadence and first line");
        for (int i = 0; i < 1700; i++) applyStimulus(1'b0);

        $display("[TB] random mid-frame resets");
        for (int r = 0; r < 6; r++) begin
            int runLen, rstLen;
            runLen = int'($urandom_range(600, 50));
            rstLen = int'($urandom_range(3, 1));
            for (int i = 0; i < runLen; i++) applyStimulus(1'b0);
            for (int i = 0; i < rstLen; i++) applyStimulus(1'b1);
        end

        $display("[TB] frame period and sync widths");
        for (int i = 0; i < 2; i++) applyStimulus(1'b1);
        firstV  = -1;
        secondV = -1;
        hCount  = 0;
        hLowA   = 0;
        prevVs  = ifB.vsync;
        prevHs  = ifB.hsync;
        for (int i = 0; i < 2400; i++) begin
            applyStimulus(1'b0);
            if (ifB.vsync === 1'b1 && prevVs !== 1'b1) begin
                if (firstV < 0) firstV = i;
                else if (secondV < 0) secondV = i;
            end
            if (firstV >= 0 && secondV < 0 && ifB.hsync === 1'b1 && prevHs !== 1'b1)
                hCount++;
            if (ifA.hsync === 1'b0) hLowA++;
            prevVs = ifB.vsync;
            prevHs = ifB.hsync;
        end
        checkField("B vsync period clks", secondV - firstV,
                   (B_HD + B_HF + B_HS + B_HB) * (B_VD + B_VF + B_VS + B_VB) * B_DIV);
        checkField("B hsync pulses per frame", hCount, B_VD + B_VF + B_VS + B_VB);
        checkField("A hsync low clks", hLowA, 96 * 2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
